// File: rtl/cdc_fifo_pkg.sv
`timescale 1ns/1ps
// cdc_fifo_pkg: Gray-code helpers and parameter legality check shared by the dual-clock FIFO.
// Functions work on 32-bit vectors so any pointer width up to 32 bits can use them.
package cdc_fifo_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic bit params_legal(input int addr_w, input int sync_stages,
                                        input int af_level, input int ae_level);
        return (addr_w >= 2) && (addr_w < MAX_PTR_W) &&
               (sync_stages >= 2) &&
               (af_level >= 1) && (af_level <= (1 << addr_w)) &&
               (ae_level >= 0) && (ae_level <= (1 << addr_w) - 1);
    endfunction

endpackage

// File: rtl/cdc_gray_sync.sv
`timescale 1ns/1ps
// cdc_gray_sync: multi-flop synchronizer for a Gray-coded pointer entering the clk domain.
// Only one bit of d changes per source update, so each stage sees a clean or one-off value.
module cdc_gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_fifo_param.sv
`timescale 1ns/1ps
// cdc_fifo_param: dual-clock FIFO with Gray-coded pointer crossing and pessimistic status flags.
// Define CDC_FIFO_FWFT_EN for first-word-fall-through read data; otherwise data_out is registered.
module cdc_fifo_param
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 6,
    parameter int AE_LEVEL    = 1
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              rclk,
    input  logic              rrst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

    if (!params_legal(ADDR_W, SYNC_STAGES, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("cdc_fifo_param: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PTR_W-1:0] wptr, wptr_next, wgray;
    logic [PTR_W-1:0] rgray_wsync, rptr_wsync;
    logic             w_accept;

    assign w_accept  = w_en & ~full;
    assign wptr_next = wptr + PTR_W'(1);

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wptr        <= '0;
            wgray       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            wr_overflow <= w_en & full;
            if (w_accept) begin
                wptr  <= wptr_next;
                wgray <= PTR_W'(bin2gray(32'(wptr_next)));
            end
        end
    end

    // NOTE: storage has no reset; a flush only moves the pointers, stale words are unreachable.
    always_ff @(posedge wclk) begin
        if (w_accept) begin
            mem[wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    cdc_gray_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rgray_sync (
        .clk   (wclk),
        .rst_n (wrst),
        .d     (rgray),
        .q     (rgray_wsync)
    );

    assign rptr_wsync  = PTR_W'(gray2bin(32'(rgray_wsync)));
    // Full when the write pointer is one lap ahead: top two Gray bits differ, the rest match.
    assign full        = (wgray == {~rgray_wsync[PTR_W-1 -: 2], rgray_wsync[PTR_W-3:0]});
    assign wr_level    = wptr - rptr_wsync;
    assign almost_full = (wr_level >= AF_LVL);

    // ---------------- read domain ----------------
    logic [PTR_W-1:0] rptr, rptr_next, rgray;
    logic [PTR_W-1:0] wgray_rsync, wptr_rsync;
    logic             r_accept;

    assign r_accept  = r_en & ~empty;
    assign rptr_next = rptr + PTR_W'(1);

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            rptr         <= '0;
            rgray        <= '0;
            rd_underflow <= 1'b0;
        end else begin
            rd_underflow <= r_en & empty;
            if (r_accept) begin
                rptr  <= rptr_next;
                rgray <= PTR_W'(bin2gray(32'(rptr_next)));
            end
        end
    end

    cdc_gray_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wgray_sync (
        .clk   (rclk),
        .rst_n (rrst),
        .d     (wgray),
        .q     (wgray_rsync)
    );

    assign wptr_rsync   = PTR_W'(gray2bin(32'(wgray_rsync)));
    assign empty        = (rgray == wgray_rsync);
    assign rd_level     = wptr_rsync - rptr;
    assign almost_empty = (rd_level <= AE_LVL);

`ifdef CDC_FIFO_FWFT_EN
    // Head word is visible as soon as the synchronized write pointer shows it; zero while empty.
    assign data_out = empty ? '0 : mem[rptr[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            data_q <= '0;
        end else if (r_accept) begin
            data_q <= mem[rptr[ADDR_W-1:0]];
        end
    end

    assign data_out = data_q;
`endif

endmodule

// File: tb/tb_cdc_fifo_param.sv
`timescale 1ns/1ps
// tb_cdc_fifo_param: directed and randomized checks of the dual-clock FIFO against a queue model.
// Works for both the registered and the CDC_FIFO_FWFT_EN read-data builds.
module tb_cdc_fifo_param;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int AF_LEVEL    = 6;
    localparam int AE_LEVEL    = 1;
    localparam int DEPTH       = 1 << ADDR_W;

    logic              wclk, wrst, rclk, rrst;
    logic              w_en, r_en;
    logic [DATA_W-1:0] data_in, data_out;
    logic              full, almost_full, wr_overflow;
    logic              empty, almost_empty, rd_underflow;
    logic [ADDR_W:0]   wr_level, rd_level;

    cdc_fifo_param #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES),
        .AF_LEVEL    (AF_LEVEL),
        .AE_LEVEL    (AE_LEVEL)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .rclk         (rclk),
        .rrst         (rrst),
        .w_en         (w_en),
        .data_in      (data_in),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .wr_overflow  (wr_overflow),
        .r_en         (r_en),
        .data_out     (data_out),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .rd_underflow (rd_underflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;
    initial rclk = 1'b0;
    always #13.5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_cnt  = 0;
    int unf_cnt  = 0;
    int rclk_edges  = 0;
    int edge_at_wr  = 0;
    int reads_done  = 0;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] last_data = '0;

    always @(posedge rclk) rclk_edges++;
    always @(negedge wclk) if (wr_overflow === 1'b1) ovf_cnt++;
    always @(negedge rclk) if (rd_underflow === 1'b1) unf_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d);
        bit acc;
        @(negedge wclk);
        acc     = (full === 1'b0);
        w_en    = 1'b1;
        data_in = d;
        @(posedge wclk);
        edge_at_wr = rclk_edges;
        #1;
        w_en = 1'b0;
        if (acc) model_q.push_back(d);
    endtask

    task automatic do_read(output bit acc);
        @(negedge rclk);
        acc = (empty === 1'b0);
`ifdef CDC_FIFO_FWFT_EN
        if (acc && model_q.size() != 0) check("rd_head", 32'(data_out), 32'(model_q[0]));
        else if (!acc) check("rd_empty_data", 32'(data_out), 32'h0);
`endif
        r_en = 1'b1;
        @(posedge rclk);
        #1;
        r_en = 1'b0;
        if (acc) begin
            check_bit("rd_model_nonempty", model_q.size() != 0, 1'b1);
            if (model_q.size() != 0) last_data = model_q.pop_front();
            reads_done++;
        end
`ifndef CDC_FIFO_FWFT_EN
        check("rd_data", 32'(data_out), 32'(last_data));
`endif
    endtask

    task automatic wait_not_full();
        int k = 0;
        while (full === 1'b1 && k < 500) begin
            @(negedge wclk);
            k++;
        end
        if (k >= 500) check_bit("wait_not_full_timeout", full, 1'b0);
    endtask

    task automatic wait_not_empty();
        int k = 0;
        while (empty === 1'b1 && k < 200) begin
            @(negedge rclk);
            k++;
        end
        if (k >= 200) check_bit("wait_not_empty_timeout", empty, 1'b0);
    endtask

    task automatic settle();
        repeat (SYNC_STAGES + 2) @(posedge rclk);
        repeat (SYNC_STAGES + 2) @(posedge wclk);
        @(negedge wclk);
    endtask

    // Once both synchronizers have caught up, every status output follows from the stored count.
    task automatic check_levels(input string tag);
        int n;
        n = model_q.size();
        check({tag, "_wr_level"}, 32'(wr_level), 32'(n));
        check({tag, "_rd_level"}, 32'(rd_level), 32'(n));
        check_bit({tag, "_full"}, full, n == DEPTH);
        check_bit({tag, "_almost_full"}, almost_full, n >= AF_LEVEL);
        check_bit({tag, "_empty"}, empty, n == 0);
        check_bit({tag, "_almost_empty"}, almost_empty, n <= AE_LEVEL);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int lat;

        w_en = 1'b0; r_en = 1'b0; data_in = '0;
        wrst = 1'b0; rrst = 1'b0;

        // Reset values
        repeat (3) @(posedge rclk);
        @(negedge wclk);
        check_bit("rst_full", full, 1'b0);
        check_bit("rst_almost_full", almost_full, 1'b0);
        check("rst_wr_level", 32'(wr_level), 32'h0);
        check_bit("rst_wr_overflow", wr_overflow, 1'b0);
        check_bit("rst_empty", empty, 1'b1);
        check_bit("rst_almost_empty", almost_empty, 1'b1);
        check("rst_rd_level", 32'(rd_level), 32'h0);
        check_bit("rst_rd_underflow", rd_underflow, 1'b0);
        check("rst_data_out", 32'(data_out), 32'h0);
        @(negedge rclk);
        wrst = 1'b1; rrst = 1'b1;
        repeat (3) @(posedge wclk);

        // Write-to-not-empty latency
        do_write(8'h3C);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge rclk);
            #1;
            if (empty === 1'b0) break;
        end
        lat = rclk_edges - edge_at_wr;
        check_bit("latency_in_range", (lat >= SYNC_STAGES) && (lat <= SYNC_STAGES + 1), 1'b1);
        check("latency_rd_level", 32'(rd_level), 32'h1);
        check_bit("latency_almost_empty", almost_empty, 1'b1);
`ifdef CDC_FIFO_FWFT_EN
        check("fwft_head_3c", 32'(data_out), 32'h3C);
`endif
        do_read(acc);
        check_bit("latency_read_accepted", acc, 1'b1);
        settle();
        check_levels("after_latency");

        // Fill to full, then one rejected write
        for (int i = 1; i <= DEPTH; i++) begin
            do_write(8'(i));
            check("fill_wr_level", 32'(wr_level), 32'(i));
            check_bit("fill_almost_full", almost_full, i >= AF_LEVEL);
            check_bit("fill_full", full, i == DEPTH);
        end
        do_write(8'hFF);
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        check("overflow_pulses", 32'(ovf_cnt), 32'h1);
        check("overflow_wr_level", 32'(wr_level), 32'(DEPTH));
        settle();
        check_levels("full");

        // Drain plus one rejected read
        for (int i = 1; i <= DEPTH + 1; i++) begin
            do_read(acc);
            check_bit("drain_accepted", acc, i <= DEPTH);
            if (i <= DEPTH) begin
                check_bit("drain_empty", empty, i == DEPTH);
                check_bit("drain_almost_empty", almost_empty, (DEPTH - i) <= AE_LEVEL);
                check("drain_rd_level", 32'(rd_level), 32'(DEPTH - i));
            end
        end
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        check("underflow_pulses", 32'(unf_cnt), 32'h1);
`ifndef CDC_FIFO_FWFT_EN
        check("drain_hold_08", 32'(data_out), 32'h08);
`endif
        settle();
        check_levels("drained");

        // Interleaved random-gap traffic across the pointer wrap
        reads_done = 0;
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge wclk);
                    wait_not_full();
                    do_write(8'(j));
                end
            end
            begin
                bit racc;
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 2)) @(posedge rclk);
                    wait_not_empty();
                    do_read(racc);
`ifndef CDC_FIFO_FWFT_EN
                    check("wrap_order", 32'(data_out), 32'(j));
`endif
                end
            end
        join
        settle();
        check("wrap_reads", 32'(reads_done), 32'd40);
        check("wrap_overflow_pulses", 32'(ovf_cnt), 32'h1);
        check("wrap_underflow_pulses", 32'(unf_cnt), 32'h1);
        check_levels("wrapped");

        // Flush with both resets
        for (int i = 0; i < 5; i++) do_write(8'h50 + 8'(i));
        settle();
        check("preflush_rd_level", 32'(rd_level), 32'h5);
        @(negedge rclk);
        wrst = 1'b0; rrst = 1'b0;
        repeat (SYNC_STAGES + 3) @(posedge rclk);
        #1;
        check_bit("flush_empty", empty, 1'b1);
        check_bit("flush_full", full, 1'b0);
        check("flush_data_out", 32'(data_out), 32'h0);
        check("flush_wr_level", 32'(wr_level), 32'h0);
        check("flush_rd_level", 32'(rd_level), 32'h0);
        model_q.delete();
        last_data = '0;
        @(negedge rclk);
        wrst = 1'b1; rrst = 1'b1;
        repeat (3) @(posedge wclk);
        do_write(8'h77);
        wait_not_empty();
        do_read(acc);
        check_bit("postflush_read_accepted", acc, 1'b1);
`ifndef CDC_FIFO_FWFT_EN
        check("postflush_data", 32'(data_out), 32'h77);
`endif
        settle();
        check_levels("postflush");

`ifdef CDC_FIFO_FWFT_EN
        // Head word appears without r_en
        do_write(8'hA5);
        for (int k = 0; k < 20; k++) begin
            @(posedge rclk);
            #1;
            if (empty === 1'b0) break;
        end
        check_bit("fwft_not_empty", empty, 1'b0);
        check("fwft_head_a5", 32'(data_out), 32'hA5);
        do_read(acc);
        settle();
        check_levels("fwft_done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
